// File: rtl/axi_read_rr_arbiter.sv
// axi_read_rr_arbiter
//   Merges the AR channels of NUM_MASTERS read masters onto one downstream AR
//   channel using round-robin arbitration. A single AR holding register feeds
//   the downstream channel. Every grant pushes the granted master index into an
//   in-order grant FIFO. The R channel is routed to the master at the FIFO head.
//   Memory is assumed to return bursts in AR order.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   m_ar{valid,ready,id,len,addr}  per-master AR channels (flattened vectors)
//   m_r{valid,ready}          per-master R handshake
//   m_r{last,id,data}         broadcast copies of the downstream R payload
//   s_ar*, s_r*               downstream AR / R channels
//   outstanding               bursts granted but not yet completed
//   err_unexp_r               sticky: R beat seen while the grant FIFO was empty
module axi_read_rr_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int LEN_WIDTH   = 4,
  parameter int OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_arid,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  m_arlen,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic                              m_rlast,
  output logic [ID_WIDTH-1:0]               m_rid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              s_arvalid,
  input  logic                              s_arready,
  output logic [ID_WIDTH-1:0]               s_arid,
  output logic [LEN_WIDTH-1:0]              s_arlen,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  input  logic                              s_rvalid,
  output logic                              s_rready,
  input  logic                              s_rlast,
  input  logic [ID_WIDTH-1:0]               s_rid,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  output logic [$clog2(OUTSTANDING):0]      outstanding,
  output logic                              err_unexp_r
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_HOLD = 1'b1
  } ar_state_e;

  ar_state_e             ar_state_q, ar_state_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [LEN_WIDTH-1:0]  ar_len_q, ar_len_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W-1:0]      fifo_q [OUTSTANDING];
  logic [IDX_W-1:0]      fifo_d [OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  full_s;
  logic                  empty_s;
  logic                  ar_free_s;
  logic                  grant_s;
  logic                  req_found_s;
  logic [IDX_W-1:0]      gnt_idx_s;
  logic [IDX_W:0]        cand_s;
  logic [IDX_W-1:0]      head_s;
  logic                  pop_s;

  assign full_s  = (cnt_q == CNT_W'(OUTSTANDING));
  assign empty_s = (cnt_q == {CNT_W{1'b0}});
  assign head_s  = fifo_q[rd_ptr_q];

  // Round-robin search: first requester at or after rr_q, wrapping modulo NUM_MASTERS.
  always_comb begin
    req_found_s = 1'b0;
    gnt_idx_s   = {IDX_W{1'b0}};
    cand_s      = {(IDX_W+1){1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand_s = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand_s >= (IDX_W+1)'(NUM_MASTERS)) begin
        cand_s = cand_s - (IDX_W+1)'(NUM_MASTERS);
      end else begin
        cand_s = cand_s;
      end
      if (!req_found_s && m_arvalid[cand_s[IDX_W-1:0]]) begin
        req_found_s = 1'b1;
        gnt_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        req_found_s = req_found_s;
      end
    end
  end

  // AR next-state: the holding register may take a new request when empty or
  // draining this cycle; a pop in the same cycle does not free a FIFO slot.
  always_comb begin
    ar_state_d = ar_state_q;
    ar_id_d    = ar_id_q;
    ar_len_d   = ar_len_q;
    ar_addr_d  = ar_addr_q;
    rr_d       = rr_q;
    case (ar_state_q)
      AR_IDLE: ar_free_s = 1'b1;
      AR_HOLD: ar_free_s = s_arready;
      default: ar_free_s = 1'b0;
    endcase
    grant_s = ar_free_s && !full_s && req_found_s;
    if (grant_s) begin
      ar_state_d = AR_HOLD;
      ar_id_d    = m_arid[gnt_idx_s*ID_WIDTH +: ID_WIDTH];
      ar_len_d   = m_arlen[gnt_idx_s*LEN_WIDTH +: LEN_WIDTH];
      ar_addr_d  = m_araddr[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
      if (gnt_idx_s == IDX_W'(NUM_MASTERS - 1)) begin
        rr_d = {IDX_W{1'b0}};
      end else begin
        rr_d = gnt_idx_s + IDX_W'(1);
      end
    end else if ((ar_state_q == AR_HOLD) && s_arready) begin
      ar_state_d = AR_IDLE;
    end else begin
      ar_state_d = ar_state_q;
    end
  end

  // One-hot master AR ready for the granted master.
  always_comb begin
    m_arready = {NUM_MASTERS{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_arready[i] = grant_s && (gnt_idx_s == IDX_W'(i));
    end
  end

  // R routing to the FIFO-head owner; beats with an empty FIFO are stalled.
  always_comb begin
    m_rvalid = {NUM_MASTERS{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_rvalid[i] = s_rvalid && !empty_s && (head_s == IDX_W'(i));
    end
    s_rready = !empty_s && m_rready[head_s];
    pop_s    = s_rvalid && s_rready && s_rlast;
  end

  // Grant FIFO write, pointer and occupancy update, sticky error.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (grant_s) begin
      fifo_d[wr_ptr_q] = gnt_idx_s;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({grant_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (s_rvalid & empty_s);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_state_q <= AR_IDLE;
      ar_id_q    <= {ID_WIDTH{1'b0}};
      ar_len_q   <= {LEN_WIDTH{1'b0}};
      ar_addr_q  <= {ADDR_WIDTH{1'b0}};
      rr_q       <= {IDX_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        fifo_q[i] <= {IDX_W{1'b0}};
      end
    end else begin
      ar_state_q <= ar_state_d;
      ar_id_q    <= ar_id_d;
      ar_len_q   <= ar_len_d;
      ar_addr_q  <= ar_addr_d;
      rr_q       <= rr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fifo_q     <= fifo_d;
    end
  end

  assign s_arvalid   = (ar_state_q == AR_HOLD);
  assign s_arid      = ar_id_q;
  assign s_arlen     = ar_len_q;
  assign s_araddr    = ar_addr_q;
  assign m_rlast     = s_rlast;
  assign m_rid       = s_rid;
  assign m_rdata     = s_rdata;
  assign outstanding = cnt_q;
  assign err_unexp_r = err_q;

endmodule

// File: tb/tb_axi_read_rr_arbiter.sv
// Self-checking bench for axi_read_rr_arbiter: randomized masters and memory,
// a spec-level reference model predicting grants/routing, and a scoreboard
// monitor comparing downstream AR and per-master R beats.
module tb_axi_read_rr_arbiter;
  localparam int NM = 3;
  localparam int IW = 4;
  localparam int LW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OS = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NM*IW-1:0] m_arid;
  logic [NM*LW-1:0] m_arlen;
  logic [NM*AW-1:0] m_araddr;
  logic             m_rlast, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, err_unexp_r;
  logic [IW-1:0]    m_rid, s_arid, s_rid;
  logic [DW-1:0]    m_rdata, s_rdata;
  logic [LW-1:0]    s_arlen;
  logic [AW-1:0]    s_araddr;
  logic [$clog2(OS):0] outstanding;

  axi_read_rr_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .ID_WIDTH(IW), .LEN_WIDTH(LW), .OUTSTANDING(OS)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_araddr(m_araddr), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .m_rid(m_rid), .m_rdata(m_rdata), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_araddr(s_araddr), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .s_rlast(s_rlast), .s_rid(s_rid), .s_rdata(s_rdata),
    .outstanding(outstanding), .err_unexp_r(err_unexp_r));

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [IW-1:0] id; logic [LW-1:0] len; logic [AW-1:0] addr; } req_t;
  typedef struct packed { logic [7:0] mst; logic [DW-1:0] data; logic [IW-1:0] id; logic last; } beat_t;
  typedef struct packed { req_t r; logic [7:0] beat; } burst_t;

  req_t   pend [NM][$];   // per-master requests waiting to be presented
  req_t   ar_exp[$];      // expected downstream AR sequence
  beat_t  beat_exp[$];    // expected R beats, in grant order
  burst_t mem_q[$];       // memory's accepted bursts
  int     gq[$];          // model grant-order FIFO

  int total = 0;
  int bad   = 0;
  int ar_ready_pct = 100, r_valid_pct = 100, rready_pct = 100;
  bit rogue = 1'b0;
  int rr_m = 0;
  bit ar_pend_m = 1'b0, err_m = 1'b0;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a, input int b);
    return a ^ (32'(b) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: predicts grants, routing, occupancy and error from the rules.
  initial begin : predictor
    logic [NM-1:0] exp_rv, exp_ar;
    logic exp_rr, pop;
    bit gok;
    int win, c;
    req_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        rr_m = 0; ar_pend_m = 1'b0; err_m = 1'b0; gq.delete();
      end else begin
        exp_rv = '0;
        if (gq.size() > 0 && s_rvalid) exp_rv[gq[0]] = 1'b1;
        exp_rr = (gq.size() > 0) && m_rready[gq[0]];
        chk("m_rvalid", 64'(m_rvalid), 64'(exp_rv));
        chk("s_rready", 64'(s_rready), 64'(exp_rr));
        chk("outstanding", 64'(outstanding), 64'(gq.size()));
        chk("s_arvalid", 64'(s_arvalid), 64'(ar_pend_m));
        chk("err_unexp_r", 64'(err_unexp_r), 64'(err_m));
        gok = (!ar_pend_m || s_arready) && (gq.size() < OS);
        win = -1;
        if (gok) begin
          for (int j = 0; j < NM; j++) begin
            c = (rr_m + j) % NM;
            if (win < 0 && m_arvalid[c]) win = c;
          end
        end
        exp_ar = '0;
        if (win >= 0) exp_ar[win] = 1'b1;
        chk("m_arready", 64'(m_arready), 64'(exp_ar));
        pop = s_rvalid && exp_rr && s_rlast;
        if (s_rvalid && gq.size() == 0) err_m = 1'b1;
        if (pop) void'(gq.pop_front());
        if (win >= 0) begin
          r.id   = m_arid[win*IW +: IW];
          r.len  = m_arlen[win*LW +: LW];
          r.addr = m_araddr[win*AW +: AW];
          ar_exp.push_back(r);
          for (int b = 0; b <= int'(r.len); b++)
            beat_exp.push_back('{mst: 8'(win), data: mem_data(r.addr, b), id: r.id,
                                 last: (b == int'(r.len))});
          gq.push_back(win);
          rr_m = (win + 1) % NM;
          ar_pend_m = 1'b1;
        end else if (s_arready) begin
          ar_pend_m = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: pops expectations on every downstream AR and master R handshake.
  initial begin : monitor
    req_t e;
    beat_t b;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        ar_exp.delete(); beat_exp.delete();
      end else begin
        if (s_arvalid && s_arready) begin
          chk("ar_expected_present", 64'(ar_exp.size() > 0), 64'd1);
          if (ar_exp.size() > 0) begin
            e = ar_exp.pop_front();
            chk("s_arid", 64'(s_arid), 64'(e.id));
            chk("s_arlen", 64'(s_arlen), 64'(e.len));
            chk("s_araddr", 64'(s_araddr), 64'(e.addr));
          end
        end
        for (int i = 0; i < NM; i++) begin
          if (m_rvalid[i] && m_rready[i]) begin
            chk("r_expected_present", 64'(beat_exp.size() > 0), 64'd1);
            if (beat_exp.size() > 0) begin
              b = beat_exp.pop_front();
              chk("r_master", 64'(i), 64'(b.mst));
              chk("m_rdata", 64'(m_rdata), 64'(b.data));
              chk("m_rid", 64'(m_rid), 64'(b.id));
              chk("m_rlast", 64'(m_rlast), 64'(b.last));
            end
          end
        end
      end
    end
  end

  // Master drivers: present queued requests, hold until granted; random R ready.
  initial begin : masters
    logic [NM-1:0] hs;
    req_t r;
    m_arvalid = '0; m_arid = '0; m_arlen = '0; m_araddr = '0; m_rready = '0;
    forever begin
      @(negedge clk);
      hs = m_arvalid & m_arready;
      @(posedge clk); #1;
      if (rst) begin
        for (int i = 0; i < NM; i++) pend[i].delete();
        m_arvalid = '0; m_rready = '0;
      end else begin
        for (int i = 0; i < NM; i++) begin
          if (hs[i] || !m_arvalid[i]) begin
            if (pend[i].size() > 0) begin
              r = pend[i].pop_front();
              m_arvalid[i] = 1'b1;
              m_arid[i*IW +: IW]   = r.id;
              m_arlen[i*LW +: LW]  = r.len;
              m_araddr[i*AW +: AW] = r.addr;
            end else begin
              m_arvalid[i] = 1'b0;
            end
          end
          m_rready[i] = ($urandom % 100) < rready_pct;
        end
      end
    end
  end

  // Memory model: accepts ARs, returns bursts in order with random gaps.
  initial begin : memory
    bit ar_hs, r_hs;
    req_t arq;
    burst_t t;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rid = '0; s_rdata = '0;
    forever begin
      @(negedge clk);
      ar_hs = s_arvalid && s_arready;
      arq   = '{id: s_arid, len: s_arlen, addr: s_araddr};
      r_hs  = s_rvalid && s_rready;
      @(posedge clk); #1;
      if (rst) begin
        mem_q.delete();
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rid = '0; s_rdata = '0;
      end else begin
        if (r_hs && mem_q.size() > 0) begin
          t = mem_q[0];
          if (t.beat == 8'(t.r.len)) void'(mem_q.pop_front());
          else begin t.beat = t.beat + 8'd1; mem_q[0] = t; end
        end
        if (ar_hs) mem_q.push_back('{r: arq, beat: 8'd0});
        s_arready = ($urandom % 100) < ar_ready_pct;
        if (rogue) begin
          s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = '0; s_rdata = 32'hDEAD_BEEF;
        end else if (s_rvalid && !r_hs && mem_q.size() > 0) begin
          s_rvalid = 1'b1;
        end else if (mem_q.size() > 0 && ($urandom % 100) < r_valid_pct) begin
          s_rvalid = 1'b1;
          s_rid    = mem_q[0].r.id;
          s_rdata  = mem_data(mem_q[0].r.addr, int'(mem_q[0].beat));
          s_rlast  = (mem_q[0].beat == 8'(mem_q[0].r.len));
        end else begin
          s_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic push_req(input int m, input int id, input int len, input logic [AW-1:0] addr);
    req_t r;
    r.id = IW'(id); r.len = LW'(len); r.addr = addr;
    pend[m].push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    bit idle = 1'b0;
    while (n < budget && !idle) begin
      @(negedge clk);
      n++;
      idle = (m_arvalid == '0) && (gq.size() == 0) && !ar_pend_m;
      for (int i = 0; i < NM; i++) if (pend[i].size() > 0) idle = 1'b0;
    end
    chk("drain_in_budget", 64'(idle), 64'd1);
    @(negedge clk); #2;
    chk("beats_left", 64'(beat_exp.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_s_arvalid"}, 64'(s_arvalid), 64'd0);
    chk({tag, "_m_arready"}, 64'(m_arready), 64'd0);
    chk({tag, "_m_rvalid"}, 64'(m_rvalid), 64'd0);
    chk({tag, "_s_rready"}, 64'(s_rready), 64'd0);
    chk({tag, "_outstanding"}, 64'(outstanding), 64'd0);
    chk({tag, "_err"}, 64'(err_unexp_r), 64'd0);
  endtask

  initial begin : main
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst");

    // single master m1, addr 0x100, 4 beats
    push_req(1, 5, 3, 32'h0000_0100);
    wait_idle(100);

    // all three masters requesting continuously
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < NM; m++) push_req(m, m + 4 * k, 0, 32'h1000 * (m + 1) + 32'(k * 16));
    wait_idle(100);

    // FIFO full: no R data, five requests
    r_valid_pct = 0;
    push_req(0, 1, 1, 32'h2000); push_req(0, 2, 0, 32'h2010);
    push_req(1, 3, 2, 32'h3000); push_req(1, 4, 0, 32'h3010);
    push_req(2, 6, 1, 32'h4000);
    repeat (12) @(negedge clk);
    chk("t3_outstanding_full", 64'(outstanding), 64'd4);
    chk("t3_fifth_waits", 64'(m_arready), 64'd0);
    r_valid_pct = 100;
    wait_idle(200);

    // m2 then m0 with a stalling m_rready
    rready_pct = 50;
    push_req(2, 7, 1, 32'h5000);
    push_req(0, 8, 0, 32'h6000);
    wait_idle(200);

    // randomized traffic with varying back-pressure
    for (int seg = 0; seg < 6; seg++) begin
      ar_ready_pct = $urandom_range(30, 100);
      r_valid_pct  = (seg == 2) ? 0 : $urandom_range(20, 100);
      rready_pct   = $urandom_range(30, 100);
      for (int cyc = 0; cyc < 100; cyc++) begin
        @(negedge clk);
        for (int m = 0; m < NM; m++)
          if (pend[m].size() < 2 && ($urandom % 100) < 30)
            push_req(m, $urandom_range(0, 15), $urandom_range(0, 7), $urandom);
      end
    end
    ar_ready_pct = 100; r_valid_pct = 100; rready_pct = 100;
    wait_idle(3000);

    // reset while HOLD with two outstanding bursts
    ar_ready_pct = 0; r_valid_pct = 0;
    push_req(1, 9, 1, 32'h7000);
    push_req(2, 10, 1, 32'h8000);
    repeat (3) @(negedge clk);
    ar_ready_pct = 100;
    @(negedge clk);
    ar_ready_pct = 0;
    @(negedge clk);
    chk("t6_outstanding", 64'(outstanding), 64'd2);
    chk("t6_hold", 64'(s_arvalid), 64'd1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check_reset_state("t6");
    ar_ready_pct = 100; r_valid_pct = 100;
    push_req(0, 11, 0, 32'h9000);
    push_req(1, 12, 0, 32'h9100);
    push_req(2, 13, 0, 32'h9200);
    @(negedge clk);
    chk("t6_rr_ptr_zero", 64'(m_arready), 64'd1);
    wait_idle(100);

    // unexpected R beat with nothing granted
    rogue = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_s_rready", 64'(s_rready), 64'd0);
    chk("t5_m_rvalid", 64'(m_rvalid), 64'd0);
    chk("t5_err_set", 64'(err_unexp_r), 64'd1);
    rogue = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", 64'(err_unexp_r), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
